alu_reg_sequencer: RTL
======================

Name: alu_reg_sequencer

Overview:
- Instruction-driven controller wrapped around the team's 6-bit combinational ALU (4-bit op select, active-high ALU clear, O/Cout/Zero outputs).
- Owns a 4-entry × 6-bit register file and accepts one instruction at a time over a valid/ready handshake.
- For each ALU instruction it sequences one ALU evaluation, writes the result back, and latches the carry and zero flags.
- Sits between the instruction source (test host or future decoder) and the ALU instance.

Parameters:
- NREG, 4, register-file depth; fixed, register indices are 2 bits.
- W, 6, datapath width; must match the ALU width.
- CNT_W, 8, width of the executed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear, highest priority after reset.
- ins_valid  in  1  instruction present.
- ins_ready  out  1  controller can accept an instruction.
- ins_ld  in  1  1 = load immediate, 0 = ALU operation.
- ins_op  in  4  ALU op select (ignored when ins_ld=1).
- ins_rd  in  2  destination register.
- ins_ra  in  2  source register for the ALU A input.
- ins_rb  in  2  source register for the ALU B input.
- ins_imm  in  W  immediate value for a load.
- alu_s  out  4  drives ALU op select.
- alu_a  out  W  drives ALU A.
- alu_b  out  W  drives ALU B.
- alu_r  out  1  drives ALU clear (active high).
- alu_o  in  W  ALU result.
- alu_cout  in  1  ALU carry/borrow out.
- alu_zero  in  1  ALU zero flag.
- done  out  1  one-cycle pulse: instruction retired.
- res  out  W  last value written to the register file.
- flag_c  out  1  carry flag from the last ALU op.
- flag_z  out  1  zero flag from the last ALU op.
- op_cnt  out  CNT_W  count of retired ALU ops; wraps.
- dbg_sel  in  2  register-file read select.
- dbg_data  out  W  combinational read of reg[dbg_sel].

Behaviour:
- Reset (rst_n=0, async): all registers and the remaining outputs clear to 0.
  - Registers/outputs: regs=0, res=0, flag_c=0, flag_z=0, op_cnt=0, done=0, state=IDLE.
  - In IDLE, ins_ready=1 and alu_r=1.
- Three states: IDLE, EXEC, DONE.
- ins_ready=1 only in IDLE with clr=0. Handshake completes at the edge where ins_valid & ins_ready.
- IDLE, load accepted (ins_ld=1):
  - At the accept edge, reg[ins_rd] <= ins_imm and res <= ins_imm.
  - Flags and op_cnt are unchanged.
  - Next state DONE.
- IDLE, ALU op accepted (ins_ld=0):
  - At the accept edge, latch op/rd/ra/rb.
  - Next state EXEC.
- EXEC (exactly 1 cycle):
  - Outputs: alu_r=0, alu_s=latched op, alu_a=reg[ra], alu_b=reg[rb].
  - At the closing edge:
    - reg[rd] <= alu_o, res <= alu_o.
    - flag_c <= alu_cout, flag_z <= alu_zero.
    - op_cnt <= op_cnt+1 (mod 2^CNT_W).
  - Next state DONE.
  - rd may equal ra or rb: operands are read during EXEC and the write occurs at the end of EXEC, so old values are used.
- DONE (1 cycle): done=1, ins_ready=0, then IDLE.
- Throughput and latency:
  - ALU op: 3 cycles accept-to-accept; done is asserted in the 2nd cycle after acceptance.
  - Load: 2 cycles accept-to-accept; done is asserted the cycle after acceptance.
- alu_r=1 in every state except EXEC; alu_s/alu_a/alu_b are 0 outside EXEC.
- Flags and results are taken verbatim from the ALU. Subtract borrow appears as Cout=1 (7-bit wrap semantics).
- clr=1 (sync, any state):
  - At the edge, regs/res/flags/op_cnt go to 0 and the state goes to IDLE.
  - An in-flight instruction is discarded: no write, no done.
  - While clr=1: ins_ready=0 and alu_r=1.
- Reset asserted mid-EXEC: state returns to IDLE immediately, with no writeback.
- ins_valid held without ready: the instruction fields must stay stable. The controller samples them only at the accept edge.
- dbg_data is combinational. It reflects a write on the cycle after the write edge.

Test Plan:
- Reset, then LD R0=0x2A, LD R1=0x17 -> done pulse after each; dbg_data(R0)=0x2A, dbg_data(R1)=0x17; flags=0, op_cnt=0.
- ADD (op 0000) rd=R2, ra=R0, rb=R1 -> R2=0x01, res=0x01, flag_c=1, flag_z=0, op_cnt=1; done 2 cycles after accept; ins_ready low for 2 cycles.
- SUB (op 0001) rd=R3, ra=R1, rb=R0 -> R3=0x2D, flag_c=1; then XOR (op 1100) rd=R0, ra=R0, rb=R0 -> R0=0x00, flag_z=1, flag_c=0.
- Back-to-back: ins_valid held high with 4 ALU ops queued -> accepts exactly every 3 cycles; alu_r=0 only in EXEC cycles; op_cnt increments by 4.
- clr asserted during EXEC of an INC A (op 0100) on R2 -> no done; all regs/flags/op_cnt 0; ins_ready=1 the cycle after clr deasserts.
- Preload op_cnt to 255 via 255 NAND ops (op 1101), then one more op -> op_cnt wraps to 0; rst_n pulsed low mid-DONE -> done drops at once, all outputs 0.

Source files
------------

// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer: instruction-driven controller around the 6-bit combinational ALU.
// Holds a 4 x W register file and accepts one instruction at a time over valid/ready.
// Loads retire in 2 cycles: IDLE, then DONE.
// ALU ops retire in 3 cycles: IDLE, then EXEC, then DONE.
// EXEC drives the ALU for exactly one cycle and writes the result back at its closing edge.
module alu_reg_sequencer #(
   parameter int NREG  = 4,
   parameter int W     = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ins_valid,
   output logic             ins_ready,
   input  logic             ins_ld,
   input  logic [3:0]       ins_op,
   input  logic [1:0]       ins_rd,
   input  logic [1:0]       ins_ra,
   input  logic [1:0]       ins_rb,
   input  logic [W-1:0]     ins_imm,
   output logic [3:0]       alu_s,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic             alu_r,
   input  logic [W-1:0]     alu_o,
   input  logic             alu_cout,
   input  logic             alu_zero,
   output logic             done,
   output logic [W-1:0]     res,
   output logic             flag_c,
   output logic             flag_z,
   output logic [CNT_W-1:0] op_cnt,
   input  logic [1:0]       dbg_sel,
   output logic [W-1:0]     dbg_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       regs_q [NREG];
   logic [W-1:0]       regs_d [NREG];
   logic [W-1:0]       res_q, res_d;
   logic               flag_c_q, flag_c_d;
   logic               flag_z_q, flag_z_d;
   logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
   logic [3:0]         op_q, op_d;
   logic [1:0]         rd_q, rd_d;
   logic [1:0]         ra_q, ra_d;
   logic [1:0]         rb_q, rb_d;
   logic               accept_s;

   // Handshake: only an idle controller that is not being cleared takes an instruction.
   always_comb begin
      ins_ready = 1'b0;
      if ((state_q == ST_IDLE) && !clr) begin
         ins_ready = 1'b1;
      end else begin
         ins_ready = 1'b0;
      end
      accept_s = ins_ready & ins_valid;
   end

   // Next-state and register-file update; clr overrides everything and drops any in-flight work.
   always_comb begin
      state_d  = state_q;
      regs_d   = regs_q;
      res_d    = res_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      op_cnt_d = op_cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      if (clr) begin
         state_d  = ST_IDLE;
         for (int i = 0; i < NREG; i++) begin
            regs_d[i] = {W{1'b0}};
         end
         res_d    = {W{1'b0}};
         flag_c_d = 1'b0;
         flag_z_d = 1'b0;
         op_cnt_d = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  if (ins_ld) begin
                     // Immediate load retires straight through DONE; flags and counter untouched.
                     regs_d[ins_rd] = ins_imm;
                     res_d          = ins_imm;
                     state_d        = ST_DONE;
                  end else begin
                     op_d    = ins_op;
                     rd_d    = ins_rd;
                     ra_d    = ins_ra;
                     rb_d    = ins_rb;
                     state_d = ST_EXEC;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_EXEC: begin
               // Operands were read from regs_q during EXEC, so rd aliasing ra/rb sees old values.
               regs_d[rd_q] = alu_o;
               res_d        = alu_o;
               flag_c_d     = alu_cout;
               flag_z_d     = alu_zero;
               op_cnt_d     = op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d      = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {W{1'b0}};
         end
         res_q    <= {W{1'b0}};
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
         op_cnt_q <= {CNT_W{1'b0}};
         op_q     <= 4'd0;
         rd_q     <= 2'd0;
         ra_q     <= 2'd0;
         rb_q     <= 2'd0;
      end else begin
         state_q  <= state_d;
         regs_q   <= regs_d;
         res_q    <= res_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
         op_cnt_q <= op_cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
      end
   end

   // ALU drive: operands only during EXEC, ALU held in clear otherwise or while clr is high.
   always_comb begin
      alu_s = 4'd0;
      alu_a = {W{1'b0}};
      alu_b = {W{1'b0}};
      alu_r = 1'b1;
      if (state_q == ST_EXEC) begin
         alu_s = op_q;
         alu_a = regs_q[ra_q];
         alu_b = regs_q[rb_q];
         alu_r = clr;
      end else begin
         alu_r = 1'b1;
      end
   end

   // Status outputs straight from the registered state.
   always_comb begin
      done     = (state_q == ST_DONE);
      res      = res_q;
      flag_c   = flag_c_q;
      flag_z   = flag_z_q;
      op_cnt   = op_cnt_q;
      dbg_data = regs_q[dbg_sel];
   end

endmodule
